// File: rtl/sap_core_param.sv
// sap_core_param: parametrised SAP-style accumulator core.
// Two-state fetch/execute sequencer, unified RAM with a programming port,
// carry/zero flags, conditional jumps and a clock-enable single-step mode.
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              prog_run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              step_mode,
  input  logic              step,
  output logic [DATA_W-1:0] saida,
  output logic              saida_valid,
  output logic              halted,
  output logic              flag_c,
  output logic              flag_z,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [1:0]        state_dbg
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_AND = 4'h9, OP_OR  = 4'hA, OP_XOR = 4'hB, OP_NOT = 4'hC,
                         OP_OUT = 4'hD, OP_HLT = 4'hF;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_saida;
  logic              r_saida_valid;
  logic              r_halted;
  logic              r_c;
  logic              r_z;
  logic              r_step_q;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_adv;
  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_opnd;
  logic [DATA_W-1:0] w_m;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_take;
  logic              w_exec;
  logic [DATA_W-1:0] w_acc_nx;
  logic              w_acc_we;
  logic              w_c_nx;
  logic              w_c_we;

  // Single-step turns the core into a clock-enabled machine: one advance per step rising edge.
  assign w_adv  = step_mode ? (step & ~r_step_q) : 1'b1;
  assign w_op   = r_ir[DATA_W-1 -: 4];
  assign w_opnd = r_ir[ADDR_W-1:0];
  assign w_m    = r_mem[w_opnd];
  assign w_imm  = DATA_W'(r_ir[DATA_W-5:0]);
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_m};
  assign w_diff = r_acc - w_m;
  assign w_take = (w_op == OP_JMP) | ((w_op == OP_JC) & r_c) | ((w_op == OP_JZ) & r_z);
  assign w_exec = prog_run & w_adv & (r_state == S_EXEC);

  // ALU: next accumulator value and which of ACC / carry the current opcode writes.
  always_comb begin
    w_acc_nx = r_acc;
    w_acc_we = 1'b0;
    w_c_nx   = r_c;
    w_c_we   = 1'b0;
    case (w_op)
      OP_LDA: begin w_acc_nx = w_m; w_acc_we = 1'b1; end
      OP_ADD: begin {w_c_nx, w_acc_nx} = w_sum; w_acc_we = 1'b1; w_c_we = 1'b1; end
      OP_SUB: begin w_acc_nx = w_diff; w_c_nx = (r_acc >= w_m); w_acc_we = 1'b1; w_c_we = 1'b1; end
      OP_LDI: begin w_acc_nx = w_imm; w_acc_we = 1'b1; end
      OP_AND: begin w_acc_nx = r_acc & w_m; w_acc_we = 1'b1; end
      OP_OR:  begin w_acc_nx = r_acc | w_m; w_acc_we = 1'b1; end
      OP_XOR: begin w_acc_nx = r_acc ^ w_m; w_acc_we = 1'b1; end
      OP_NOT: begin w_acc_nx = ~r_acc; w_acc_we = 1'b1; end
      default: ;
    endcase
  end

  // RAM writes: programming port while held, STA while running; clear blocks both.
  always_ff @(posedge clock) begin
    if (!clear) begin
      if (!prog_run) begin
        if (prog_we) r_mem[prog_addr] <= prog_data;
      end else if (w_exec && w_op == OP_STA) begin
        r_mem[w_opnd] <= r_acc;
      end
    end
  end

  // Sequencer and architectural registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state       <= S_FETCH;
      r_pc          <= '0;
      r_ir          <= '0;
      r_acc         <= '0;
      r_saida       <= '0;
      r_saida_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_c           <= 1'b0;
      r_z           <= 1'b0;
      r_step_q      <= 1'b0;
    end else begin
      r_step_q      <= step;
      r_saida_valid <= 1'b0;
      if (!prog_run) begin
        r_state  <= S_FETCH;
        r_pc     <= '0;
        r_halted <= 1'b0;
      end else if (w_adv) begin
        case (r_state)
          S_FETCH: begin
            r_ir    <= r_mem[r_pc];
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_EXEC;
          end
          S_EXEC: begin
            r_state <= S_FETCH;
            if (w_acc_we) begin
              r_acc <= w_acc_nx;
              r_z   <= (w_acc_nx == '0);
            end
            if (w_c_we) r_c <= w_c_nx;
            if (w_take) r_pc <= w_opnd;
            if (w_op == OP_OUT) begin
              r_saida       <= r_acc;
              r_saida_valid <= 1'b1;
            end
            if (w_op == OP_HLT) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
          S_HALT: ;
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign saida       = r_saida;
  assign saida_valid = r_saida_valid;
  assign halted      = r_halted;
  assign flag_c      = r_c;
  assign flag_z      = r_z;
  assign pc_dbg      = r_pc;
  assign state_dbg   = r_state;
endmodule

// File: tb/tb_sap_core_param.sv
// Directed bench for sap_core_param: default 8/4 core plus a 12/8 variant.
module tb_sap_core_param;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        prog_run = 1'b0, prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic        step_mode = 1'b0, step = 1'b0;
  logic [7:0]  saida;
  logic        saida_valid, halted, flag_c, flag_z;
  logic [3:0]  pc_dbg;
  logic [1:0]  state_dbg;

  logic        prog_run2 = 1'b0, prog_we2 = 1'b0;
  logic [7:0]  prog_addr2 = '0;
  logic [11:0] prog_data2 = '0;
  logic [11:0] saida2;
  logic        saida_valid2, halted2, flag_c2, flag_z2;
  logic [7:0]  pc_dbg2;
  logic [1:0]  state_dbg2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock(clock), .clear(clear), .prog_run(prog_run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .step_mode(step_mode), .step(step),
    .saida(saida), .saida_valid(saida_valid), .halted(halted), .flag_c(flag_c),
    .flag_z(flag_z), .pc_dbg(pc_dbg), .state_dbg(state_dbg));

  sap_core_param #(.DATA_W(12), .ADDR_W(8)) dut2 (
    .clock(clock), .clear(clear), .prog_run(prog_run2), .prog_we(prog_we2),
    .prog_addr(prog_addr2), .prog_data(prog_data2), .step_mode(1'b0), .step(1'b0),
    .saida(saida2), .saida_valid(saida_valid2), .halted(halted2), .flag_c(flag_c2),
    .flag_z(flag_z2), .pc_dbg(pc_dbg2), .state_dbg(state_dbg2));

  // Stimulus helpers; all tasks start and end just after a falling edge.
  task automatic do_clear();
    prog_run = 1'b0; prog_run2 = 1'b0; step_mode = 1'b0; step = 1'b0; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_addr = a; prog_data = d; prog_we = 1'b1;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  task automatic load2(input logic [7:0] a, input logic [11:0] d);
    prog_addr2 = a; prog_data2 = d; prog_we2 = 1'b1;
    @(negedge clock);
    prog_we2 = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    tick(1);
    checks++; if ({saida, saida_valid, halted} !== 10'h000) begin errors++; $display("FAIL reset_out: got saida=%h v=%b h=%b want 00 0 0", saida, saida_valid, halted); end
    checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL reset_flags: got c=%b z=%b want 0 0", flag_c, flag_z); end
    checks++; if ({pc_dbg, state_dbg} !== 6'h00) begin errors++; $display("FAIL reset_pc_state: got pc=%h st=%0d want 0 0", pc_dbg, state_dbg); end
    checks++; if (saida2 !== 12'h000) begin errors++; $display("FAIL reset_saida2: got %h want 000", saida2); end
  endtask

  task automatic test_basic();
    int np;
    do_clear();
    load(4'h0, 8'h19); load(4'h1, 8'h2A); load(4'h2, 8'hD0); load(4'h3, 8'hF0);
    load(4'h9, 8'h05); load(4'hA, 8'h03);
    prog_run = 1'b1;
    np = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (saida_valid) np++;
      if (i == 7) begin checks++; if (halted !== 1'b0) begin errors++; $display("FAIL basic_halt_early: got %b want 0", halted); end end
      if (i == 8) begin checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halt_cycle8: got %b want 1", halted); end end
    end
    checks++; if (saida !== 8'h08) begin errors++; $display("FAIL basic_saida: got %h want 08", saida); end
    checks++; if (np !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", np); end
    checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL basic_flags: got c=%b z=%b want 0 0", flag_c, flag_z); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL basic_state_halt: got %0d want 2", state_dbg); end
    // Dropping prog_run leaves HALT, rewinds PC and keeps the output register.
    prog_run = 1'b0;
    tick(1);
    checks++; if ({halted, state_dbg, pc_dbg} !== 7'h00) begin errors++; $display("FAIL hold_exit: got h=%b st=%0d pc=%h want 0 0 0", halted, state_dbg, pc_dbg); end
    checks++; if (saida !== 8'h08) begin errors++; $display("FAIL hold_saida: got %h want 08", saida); end
  endtask

  task automatic test_jc();
    do_clear();
    load(4'h0, 8'h19); load(4'h1, 8'h2A); load(4'h2, 8'h75); load(4'h3, 8'hF0);
    load(4'h5, 8'h57); load(4'h6, 8'hD0); load(4'h7, 8'hF0);
    load(4'h9, 8'hFF); load(4'hA, 8'h01);
    prog_run = 1'b1;
    tick(4);
    checks++; if ({flag_c, flag_z} !== 2'b11) begin errors++; $display("FAIL jc_add_flags: got c=%b z=%b want 1 1", flag_c, flag_z); end
    tick(2);
    checks++; if (pc_dbg !== 4'h5) begin errors++; $display("FAIL jc_taken_pc: got %h want 5", pc_dbg); end
    tick(4);
    checks++; if ({saida_valid, saida} !== 9'h107) begin errors++; $display("FAIL jc_out: got v=%b saida=%h want 1 07", saida_valid, saida); end
    tick(2);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL jc_halt: got %b want 1", halted); end
  endtask

  task automatic test_sub();
    do_clear();
    load(4'h0, 8'h53); load(4'h1, 8'h3A); load(4'h2, 8'hD0); load(4'h3, 8'h3B);
    load(4'h4, 8'hD0); load(4'h5, 8'hF0); load(4'hA, 8'h05); load(4'hB, 8'hFE);
    prog_run = 1'b1;
    tick(4);
    checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags: got c=%b z=%b want 0 0", flag_c, flag_z); end
    tick(2);
    checks++; if (saida !== 8'hFE) begin errors++; $display("FAIL sub_borrow_acc: got %h want FE", saida); end
    tick(2);
    checks++; if ({flag_c, flag_z} !== 2'b11) begin errors++; $display("FAIL sub_equal_flags: got c=%b z=%b want 1 1", flag_c, flag_z); end
    tick(2);
    checks++; if ({saida_valid, saida} !== 9'h100) begin errors++; $display("FAIL sub_equal_acc: got v=%b saida=%h want 1 00", saida_valid, saida); end
  endtask

  task automatic test_step();
    do_clear();
    for (int a = 0; a < 4; a++) load(4'(a), 8'h00);
    step_mode = 1'b1; prog_run = 1'b1;
    tick(3);
    checks++; if ({pc_dbg, state_dbg} !== 6'h00) begin errors++; $display("FAIL step_idle: got pc=%h st=%0d want 0 0", pc_dbg, state_dbg); end
    step = 1'b1;
    tick(5);
    step = 1'b0;
    tick(2);
    checks++; if ({pc_dbg, state_dbg} !== {4'h1, 2'd1}) begin errors++; $display("FAIL step_held_once: got pc=%h st=%0d want 1 1", pc_dbg, state_dbg); end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; tick(1);
      step = 1'b0; tick(1);
    end
    checks++; if ({pc_dbg, state_dbg} !== {4'h2, 2'd0}) begin errors++; $display("FAIL step_four_pulses: got pc=%h st=%0d want 2 0", pc_dbg, state_dbg); end
  endtask

  task automatic test_clear_sta();
    do_clear();
    load(4'h0, 8'h1B); load(4'h1, 8'h49); load(4'hB, 8'h55); load(4'h9, 8'h11);
    prog_run = 1'b1;
    tick(3);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL clr_in_exec: got st=%0d want 1", state_dbg); end
    clear = 1'b1; prog_run = 1'b0;
    tick(1);
    clear = 1'b0;
    checks++; if ({pc_dbg, state_dbg} !== 6'h00) begin errors++; $display("FAIL clr_pc_state: got pc=%h st=%0d want 0 0", pc_dbg, state_dbg); end
    load(4'h0, 8'hD0); load(4'h1, 8'h19); load(4'h2, 8'hD0); load(4'h3, 8'hF0);
    prog_run = 1'b1;
    tick(2);
    checks++; if ({saida_valid, saida} !== 9'h100) begin errors++; $display("FAIL clr_acc_zero: got v=%b saida=%h want 1 00", saida_valid, saida); end
    tick(4);
    checks++; if (saida !== 8'h11) begin errors++; $display("FAIL clr_mem9_kept: got %h want 11", saida); end
  endtask

  task automatic test_pc_wrap();
    do_clear();
    for (int a = 0; a < 16; a++) load(4'(a), 8'h00);
    prog_run = 1'b1;
    tick(30);
    checks++; if ({pc_dbg, state_dbg} !== {4'hF, 2'd0}) begin errors++; $display("FAIL wrap_pc15: got pc=%h st=%0d want F 0", pc_dbg, state_dbg); end
    tick(1);
    checks++; if ({pc_dbg, state_dbg} !== {4'h0, 2'd1}) begin errors++; $display("FAIL wrap_pc0: got pc=%h st=%0d want 0 1", pc_dbg, state_dbg); end
    tick(2);
    checks++; if (pc_dbg !== 4'h1) begin errors++; $display("FAIL wrap_pc1: got pc=%h want 1", pc_dbg); end
  endtask

  task automatic test_wide();
    do_clear();
    load2(8'h00, 12'h5AB); load2(8'h01, 12'hD00); load2(8'h02, 12'hF00);
    prog_run2 = 1'b1;
    tick(4);
    checks++; if ({saida_valid2, saida2} !== 13'h10AB) begin errors++; $display("FAIL wide_ldi_out: got v=%b saida=%h want 1 0AB", saida_valid2, saida2); end
    tick(2);
    checks++; if ({halted2, flag_z2} !== 2'b10) begin errors++; $display("FAIL wide_halt: got h=%b z=%b want 1 0", halted2, flag_z2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jc();
    test_sub();
    test_step();
    test_clear_sta();
    test_pc_wrap();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sap_core_param.md
Name: sap_core_param

Overview:
- Parametrised, self-contained successor to the fixed 8-bit/16-word SAP computer.
- Single-clock core: PC, IR, accumulator, flags, unified RAM, ALU and output register.
- Built-in two-state fetch/execute sequencer replaces the external ring-counter control.
- Adds carry/zero flags, conditional jumps, immediate load, store, logic ops and a clock-enable single-step mode in place of clock gating.

Parameters:
- DATA_W, 8: data/instruction width. Opcode is IR[DATA_W-1:DATA_W-4]. Requires DATA_W >= 8.
- ADDR_W, 4: address width. RAM depth is 2^ADDR_W. Operand is IR[ADDR_W-1:0]. Requires ADDR_W <= DATA_W-4.

Ports:
- clock  in  1  system clock, all logic on rising edge
- clear  in  1  synchronous active-high reset
- prog_run  in  1  0 = program/hold, 1 = run
- prog_we  in  1  RAM write strobe, honoured only when prog_run=0
- prog_addr  in  ADDR_W  programming address
- prog_data  in  DATA_W  programming data
- step_mode  in  1  1 = advance only on step rising edge
- step  in  1  single-step request, level input, edge-detected internally
- saida  out  DATA_W  output register
- saida_valid  out  1  one-cycle pulse when saida is loaded
- halted  out  1  core is in HALT
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- pc_dbg  out  ADDR_W  program counter
- state_dbg  out  2  current state: 0 FETCH, 1 EXEC, 2 HALT

Behaviour:
- Reset (clear=1):
  - PC, IR, ACC, saida, saida_valid, flag_c, flag_z, halted and the step edge register all go to 0; state goes to FETCH.
  - RAM contents are preserved.
  - clear has priority over every other input.
- RAM:
  - 2^ADDR_W x DATA_W, combinational read, synchronous write.
  - When prog_run=0 and prog_we=1: mem[prog_addr] <= prog_data.
- Hold (prog_run=0):
  - state forced to FETCH; PC forced to 0; halted <= 0.
  - ACC, flags and saida are held.
- Advance enable:
  - adv = step_mode ? (step & ~step_q) : 1.
  - step_q is registered every cycle.
  - No state, PC, register, flag or RAM update occurs in a cycle with adv=0.
  - saida_valid is 0 in any cycle with adv=0.
- FETCH (adv=1): IR <= mem[PC]; PC <= PC+1, wrapping from 2^ADDR_W-1 to 0; next state EXEC.
- EXEC (adv=1): execute the opcode below, then go to FETCH (HLT goes to HALT instead). Every instruction takes exactly 2 advancing cycles. Let M = mem[operand].
  - 0 NOP: no action.
  - 1 LDA: ACC <= M.
  - 2 ADD: {C,ACC} <= ACC+M, computed at DATA_W+1 bits.
  - 3 SUB: ACC <= ACC-M; C <= (ACC>=M), unsigned, i.e. 1 = no borrow.
  - 4 STA: mem[operand] <= ACC.
  - 5 LDI: ACC <= zero-extended IR[DATA_W-5:0].
  - 6 JMP: PC <= operand.
  - 7 JC: PC <= operand if C=1, else no change.
  - 8 JZ: PC <= operand if Z=1, else no change.
  - 9 AND, A OR, B XOR: ACC <= ACC op M.
  - C NOT: ACC <= ~ACC.
  - D OUT: saida <= ACC; saida_valid = 1 for exactly one cycle, the cycle after the EXEC edge.
  - E: reserved, executes as NOP.
  - F HLT: next state HALT; halted <= 1.
- Flags:
  - Z <= (new ACC == 0) for LDA, ADD, SUB, LDI, AND, OR, XOR, NOT.
  - C is written only by ADD and SUB.
  - All other opcodes leave both flags unchanged.
- HALT:
  - No activity; step is ignored.
  - Exit only via clear, or via prog_run=0 (returns to FETCH with PC=0).
- clear during EXEC:
  - No side effect of the in-flight instruction occurs, including RAM writes from STA.

Test Plan:
- (DATA_W=8, ADDR_W=4) Load 0:0x19, 1:0x2A, 2:0xD0, 3:0xF0, 9:0x05, A:0x03, then set prog_run=1 -> saida=0x08 with a single saida_valid pulse; halted=1 on the 8th cycle after prog_run rises; C=0, Z=0.
- mem9=0xFF, memA=0x01, program LDA 9 / ADD A / JC 5 / HLT, with 5:LDI 7, 6:OUT, 7:HLT -> after ADD ACC=0x00, C=1, Z=1; jump taken; saida=0x07.
- LDI 3 / SUB A with memA=0x05 -> ACC=0xFE, C=0, Z=0. Then SUB with memA=0xFE -> ACC=0x00, C=1, Z=1.
- step_mode=1:
  - step held high for 5 cycles -> exactly one state advance.
  - 4 separate step pulses -> exactly 2 instructions completed; pc_dbg advances by 2.
- Assert clear during the EXEC cycle of STA 9 with ACC=0x55 -> mem9 unchanged; PC=0, ACC=0, state_dbg=0.
- RAM filled with NOPs -> pc_dbg goes 15 -> 0 and continues.
- Variant DATA_W=12, ADDR_W=8: LDI 0xAB then OUT -> saida=0x0AB.
